// File: rtl/gpr_bank_if.sv
// Operand/writeback bus of the GPR bank: write, flag and clear controls in,
// combinational read data and clear-engine status out.
interface gpr_bank_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          we;
  logic [1:0]    flag_op;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [AW-1:0] awr;
  logic [DW-1:0] din;
  logic [DW-1:0] nflag;
  logic          clr_req;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] flag;
  logic          busy;
  logic          done;

  modport master (
    output we, flag_op, a1, a2, awr, din, nflag, clr_req,
    input  rd1, rd2, flag, busy, done
  );

  modport slave (
    input  we, flag_op, a1, a2, awr, din, nflag, clr_req,
    output rd1, rd2, flag, busy, done
  );
endinterface

// File: rtl/gpr_bank.sv
// Two-read/one-write register bank with a relocatable flag register,
// optional write-to-read bypass and a one-register-per-cycle clear sweep.
module gpr_bank #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned FLAG_ADDR = 31,
  parameter bit          BYPASS    = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  gpr_bank_if.slave    bus
);

  localparam int unsigned   DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] FLAG_IDX = AW'(FLAG_ADDR);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_DIS    = 2'b00,
    OP_SET    = 2'b01,
    OP_SET_WR = 2'b10,
    OP_RSVD   = 2'b11
  } flag_op_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [DW-1:0] regs_q [DEPTH];
  logic [DW-1:0] regs_d [DEPTH];

  logic          idle_c;
  logic          gpr_wr_c;
  logic          flag_wr_c;
  logic [DW-1:0] rd1_c;
  logic [DW-1:0] rd2_c;
  logic [DW-1:0] flag_c;

  // Commit qualifiers; both are suppressed while the sweep owns the array.
  always_comb begin
    idle_c    = (state_q == ST_IDLE);
    gpr_wr_c  = idle_c && bus.we && (bus.awr != '0) &&
                ((bus.flag_op == OP_DIS) || (bus.flag_op == OP_SET_WR));
    flag_wr_c = idle_c &&
                ((bus.flag_op == OP_SET) || (bus.flag_op == OP_SET_WR));
  end

  // Next-state, array update and registered status.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (gpr_wr_c) begin
          regs_d[bus.awr] = bus.din;
        end
        // Flag write is applied last so it wins on awr == FLAG_ADDR.
        if (flag_wr_c) begin
          regs_d[FLAG_IDX] = bus.nflag;
        end
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      ST_CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    regs_d[0] = '0;
    busy_d    = (state_d == ST_CLEAR);
    done_d    = (state_d == ST_CLEAR) && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational read ports; bypass forwards only commits happening this edge.
  always_comb begin
    rd1_c  = regs_q[bus.a1];
    rd2_c  = regs_q[bus.a2];
    flag_c = regs_q[FLAG_IDX];
    if (BYPASS) begin
      if (flag_wr_c && (bus.a1 == FLAG_IDX)) begin
        rd1_c = bus.nflag;
      end else if (gpr_wr_c && (bus.a1 == bus.awr)) begin
        rd1_c = bus.din;
      end
      if (flag_wr_c && (bus.a2 == FLAG_IDX)) begin
        rd2_c = bus.nflag;
      end else if (gpr_wr_c && (bus.a2 == bus.awr)) begin
        rd2_c = bus.din;
      end
      if (flag_wr_c) begin
        flag_c = bus.nflag;
      end else if (gpr_wr_c && (bus.awr == FLAG_IDX)) begin
        flag_c = bus.din;
      end
    end
  end

  assign bus.rd1  = rd1_c;
  assign bus.rd2  = rd2_c;
  assign bus.flag = flag_c;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised general-purpose register bank; next generation of the CPU's two-read/one-write GPR with flag register.
- Adds configurable data width and depth, a relocatable flag register, optional write-to-read bypass, and a sequential clear engine (one register per cycle, busy/done handshake).
- Sits in the decode/writeback path. The read side feeds the ALU operands; the flag output feeds branch/compare logic.

Parameters:
DW, 32, data width of every register
AW, 5, address width; depth = 2**AW registers
FLAG_ADDR, 31, index of the flag register (must be nonzero and < 2**AW)
BYPASS, 0, 1 = reads of the register being written this cycle return the incoming value

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  GPR write enable
flag_op  input  2  00 DIS (GPR write only), 01 SET (flag only), 10 SET_AND_WR (both), 11 reserved (no update)
a1  input  AW  read address port 1
a2  input  AW  read address port 2
awr  input  AW  write address
din  input  DW  write data
nflag  input  DW  next flag value
clr_req  input  1  request a sweep clear of all registers
rd1  output  DW  read data port 1
rd2  output  DW  read data port 2
flag  output  DW  current flag register contents
busy  output  1  clear sweep in progress
done  output  1  one-cycle pulse on the last sweep cycle

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, FSM = IDLE, sweep counter 0, busy=0, done=0. Effective immediately and overrides everything, including a sweep in progress. The sweep aborts; no resume after release.
- Register 0 always reads 0. Writes to address 0 are discarded.
- Reads are combinational: rd1=regs[a1], rd2=regs[a2], flag=regs[FLAG_ADDR].
- GPR write commit condition: flag_op ∈ {DIS, SET_AND_WR}, we=1, awr≠0, FSM=IDLE. Commits din at the rising edge.
- Flag write commit condition: flag_op ∈ {SET, SET_AND_WR}, FSM=IDLE. Commits nflag to regs[FLAG_ADDR].
- Simultaneous commits with awr=FLAG_ADDR: the flag write (nflag) wins.
- flag_op=11 updates nothing, regardless of we.
- Bypass applies only when BYPASS=1, and only for commits that will occur this cycle:
  - rdN = din when aN equals awr of a committing GPR write (aN≠0).
  - rdN and flag = nflag when aN equals FLAG_ADDR, or for the flag output, when a flag write is committing. nflag has priority over din, matching the commit priority.
- BYPASS=0: all reads see pre-edge contents.
- FSM states:
  - IDLE: clr_req=1 → CLEAR, counter←1, busy←1 at the next edge.
  - CLEAR: each cycle regs[counter]←0, counter←counter+1. When counter = 2**AW−1, that register is cleared, done=1 for that cycle, next state IDLE, busy←0.
- Sweep timing: a clear takes 2**AW−1 cycles in CLEAR (31 for the defaults).
- busy and done are registered outputs.
- Writes (GPR and flag) during CLEAR are dropped, not queued. Reads during CLEAR return current contents; already-swept entries read 0. Bypass is disabled during CLEAR.
- clr_req while busy is ignored. clr_req and a write in the same IDLE cycle: the write commits, and the sweep then clears it.
- Counter wraps naturally in AW bits; it is never used past 2**AW−1.

Test Plan:
- Reset low mid-operation → all rd*/flag = 0, busy=0 immediately (before any clock edge). Release, then write awr=3 din=0xDEADBEEF flag_op=00 we=1 → next cycle rd1 (a1=3) = 0xDEADBEEF.
- Write awr=0 din=0x1234 → rd1 (a1=0) stays 0. flag_op=11 with we=1 awr=5 → reg5 unchanged.
- flag_op=10 awr=31 din=0xAAAA nflag=0x5555 → flag=0x5555 and reg31 reads 0x5555. flag_op=01 we=1 awr=4 din=7 → reg4 unchanged, flag=nflag.
- BYPASS=1: reg6=0x10, same cycle write awr=6 din=0x20 with a2=6 → rd2=0x20 combinationally before the edge. BYPASS=0: rd2=0x10 until the edge.
- Fill regs 1..31 with their index, pulse clr_req → busy high for 31 cycles, done pulses once on the last. Mid-sweep write awr=31 din=0xFF is dropped. Afterwards all reads are 0.
- Pulse clr_req, assert reset low at sweep cycle 10 → busy=0 immediately. After release no further sweeping. A second clr_req while busy has no effect on the done timing.
